// File: rtl/gelato_split_table_scheduler.sv
// Per-warp SIMT split table: round-robin issue select, branch/divergence update, reconvergence merge, writeback free.
// Latency: selection is combinational from registers; every update is visible the next cycle. Backpressure: an offer stays put until sel_ready.
module gelato_split_table_scheduler #(
    parameter int SPLIT_NUM  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int THREAD_NUM = 32,
    parameter int IDXW       = $clog2(SPLIT_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_valid,
    input  logic [ADDR_WIDTH-1:0] init_pc,
    input  logic [THREAD_NUM-1:0] init_mask,
    output logic                  sel_valid,
    output logic [ADDR_WIDTH-1:0] sel_pc,
    output logic [IDXW-1:0]       sel_num,
    output logic [THREAD_NUM-1:0] sel_mask,
    input  logic                  sel_ready,
    input  logic                  upd_valid,
    input  logic                  upd_stall,
    input  logic [ADDR_WIDTH-1:0] upd_pc,
    input  logic [IDXW-1:0]       upd_num,
    output logic [THREAD_NUM-1:0] upd_thread_mask,
    input  logic                  div_valid,
    input  logic [ADDR_WIDTH-1:0] div_pc,
    input  logic [THREAD_NUM-1:0] div_mask,
    output logic                  div_reject,
    input  logic                  wb_valid,
    input  logic [IDXW-1:0]       wb_num,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [SPLIT_NUM-1:0]  valid_q, valid_d, pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pc_q   [SPLIT_NUM];
    logic [ADDR_WIDTH-1:0] pc_d   [SPLIT_NUM];
    logic [THREAD_NUM-1:0] mask_q [SPLIT_NUM];
    logic [THREAD_NUM-1:0] mask_d [SPLIT_NUM];
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  div_reject_q, div_reject_d;

    logic                  sel_hit, free_hit, merge_hit, upd_ok;
    logic [IDXW-1:0]       sel_idx, free_idx, merge_i, merge_j, cand;
    logic [SPLIT_NUM-1:0]  ready, touched;
    logic [THREAD_NUM-1:0] div_d;

    assign ready = valid_q & ~pend_q;

    always_comb begin
        sel_hit = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 1; k <= SPLIT_NUM; k++) begin
            cand = rr_ptr_q + IDXW'(k);
            if (!sel_hit && ready[cand]) begin
                sel_hit = 1'b1;
                sel_idx = cand;
            end
        end
        // Registered valid bits: a slot freed by wb this cycle is never reused in the same cycle.
        free_hit = 1'b0;
        free_idx = '0;
        for (int k = 0; k < SPLIT_NUM; k++) begin
            if (!free_hit && !valid_q[k]) begin
                free_hit = 1'b1;
                free_idx = IDXW'(k);
            end
        end
    end

    always_comb begin
        touched = '0;
        if (sel_hit && sel_ready) touched[sel_idx] = 1'b1;
        if (upd_valid)            touched[upd_num] = 1'b1;
        if (wb_valid)             touched[wb_num]  = 1'b1;
        merge_hit = 1'b0;
        merge_i   = '0;
        merge_j   = '0;
        for (int i = 0; i < SPLIT_NUM - 1; i++) begin
            for (int j = i + 1; j < SPLIT_NUM; j++) begin
                if (!merge_hit && ready[i] && ready[j] && !touched[i] && !touched[j]
                    && pc_q[i] == pc_q[j]) begin
                    merge_hit = 1'b1;
                    merge_i   = IDXW'(i);
                    merge_j   = IDXW'(j);
                end
            end
        end
    end

    always_comb begin
        valid_d      = valid_q;
        pend_d       = pend_q;
        pc_d         = pc_q;
        mask_d       = mask_q;
        rr_ptr_d     = rr_ptr_q;
        div_reject_d = 1'b0;
        upd_ok       = 1'b0;
        div_d        = '0;
        if (state_q == ST_IDLE) begin
            if (init_valid) begin
                valid_d = '0;
                pend_d  = '0;
                for (int k = 0; k < SPLIT_NUM; k++) begin
                    pc_d[k]   = '0;
                    mask_d[k] = '0;
                end
                valid_d[0] = 1'b1;
                pc_d[0]    = init_pc;
                mask_d[0]  = init_mask;
            end
        end else begin
            if (sel_hit && sel_ready) begin
                pend_d[sel_idx] = 1'b1;
                rr_ptr_d        = sel_idx;
            end
            upd_ok = upd_valid && valid_q[upd_num] && pend_q[upd_num]
                     && !(wb_valid && wb_num == upd_num);
            div_d  = div_mask & mask_q[upd_num];
            if (upd_ok) begin
                pend_d[upd_num] = 1'b0;
                if (!upd_stall) begin
                    if (div_valid && div_d != '0 && div_d == mask_q[upd_num]) begin
                        pc_d[upd_num] = div_pc;
                    end else if (div_valid && div_d != '0) begin
                        if (free_hit) begin
                            mask_d[upd_num]  = mask_q[upd_num] & ~div_d;
                            pc_d[upd_num]    = upd_pc;
                            valid_d[free_idx] = 1'b1;
                            pend_d[free_idx]  = 1'b0;
                            pc_d[free_idx]    = div_pc;
                            mask_d[free_idx]  = div_d;
                        end else begin
                            div_reject_d = 1'b1;
                        end
                    end else begin
                        pc_d[upd_num] = upd_pc;
                    end
                end
            end
            if (wb_valid) begin
                valid_d[wb_num] = 1'b0;
                pend_d[wb_num]  = 1'b0;
            end
            if (merge_hit) begin
                mask_d[merge_i]  = mask_q[merge_i] | mask_q[merge_j];
                valid_d[merge_j] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (init_valid) state_d = ST_RUN;
            ST_RUN:  if (valid_d == '0) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            pend_q       <= '0;
            rr_ptr_q     <= IDXW'(SPLIT_NUM - 1);
            div_reject_q <= 1'b0;
            for (int k = 0; k < SPLIT_NUM; k++) begin
                pc_q[k]   <= '0;
                mask_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            rr_ptr_q     <= rr_ptr_d;
            div_reject_q <= div_reject_d;
            pc_q         <= pc_d;
            mask_q       <= mask_d;
        end
    end

    always_comb begin
        busy            = (state_q == ST_RUN);
        done            = (state_q == ST_DONE);
        sel_valid       = sel_hit;
        sel_num         = sel_hit ? sel_idx : '0;
        sel_pc          = sel_hit ? pc_q[sel_idx] : '0;
        sel_mask        = sel_hit ? mask_q[sel_idx] : '0;
        upd_thread_mask = mask_q[upd_num];
        div_reject      = div_reject_q;
    end
endmodule

// File: tb/tb_gelato_split_table_scheduler.sv
// Directed bench for gelato_split_table_scheduler: launch, update, divergence, merge, reject, drain, reset.
module tb_gelato_split_table_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        init_valid;
    logic [31:0] init_pc, init_mask;
    logic        sel_valid;
    logic [31:0] sel_pc, sel_mask;
    logic [1:0]  sel_num;
    logic        sel_ready;
    logic        upd_valid, upd_stall;
    logic [31:0] upd_pc;
    logic [1:0]  upd_num;
    logic [31:0] upd_thread_mask;
    logic        div_valid;
    logic [31:0] div_pc, div_mask;
    logic        div_reject;
    logic        wb_valid;
    logic [1:0]  wb_num;
    logic        busy, done;

    int n_chk  = 0;
    int n_fail = 0;

    gelato_split_table_scheduler #(.SPLIT_NUM(4), .ADDR_WIDTH(32), .THREAD_NUM(32)) dut (
        .clk(clk), .rst(rst),
        .init_valid(init_valid), .init_pc(init_pc), .init_mask(init_mask),
        .sel_valid(sel_valid), .sel_pc(sel_pc), .sel_num(sel_num), .sel_mask(sel_mask),
        .sel_ready(sel_ready),
        .upd_valid(upd_valid), .upd_stall(upd_stall), .upd_pc(upd_pc), .upd_num(upd_num),
        .upd_thread_mask(upd_thread_mask),
        .div_valid(div_valid), .div_pc(div_pc), .div_mask(div_mask), .div_reject(div_reject),
        .wb_valid(wb_valid), .wb_num(wb_num),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [1:0] num, input logic [31:0] pc, input logic stall,
                       input logic dv, input logic [31:0] dmask, input logic [31:0] dpc);
        upd_valid = 1'b1; upd_num = num; upd_pc = pc; upd_stall = stall;
        div_valid = dv; div_mask = dmask; div_pc = dpc;
        step();
        upd_valid = 1'b0; upd_stall = 1'b0; div_valid = 1'b0;
    endtask

    task automatic wb(input logic [1:0] num);
        wb_valid = 1'b1; wb_num = num;
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; init_valid = 1'b0; init_pc = '0; init_mask = '0; sel_ready = 1'b0;
        upd_valid = 1'b0; upd_stall = 1'b0; upd_pc = '0; upd_num = '0;
        div_valid = 1'b0; div_pc = '0; div_mask = '0; wb_valid = 1'b0; wb_num = '0;
        step(); step();
        chk("rst_sel_valid", sel_valid, 0);
        chk("rst_sel_pc", sel_pc, 0);
        chk("rst_sel_num", sel_num, 0);
        chk("rst_sel_mask", sel_mask, 0);
        chk("rst_div_reject", div_reject, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_upd_mask", upd_thread_mask, 0);
        rst = 1'b0;

        // launch
        init_valid = 1'b1; init_pc = 32'h100; init_mask = 32'hFFFF_FFFF;
        step();
        init_valid = 1'b0;
        chk("init_sel_valid", sel_valid, 1);
        chk("init_sel_num", sel_num, 0);
        chk("init_sel_pc", sel_pc, 32'h100);
        chk("init_sel_mask", sel_mask, 32'hFFFF_FFFF);
        chk("init_busy", busy, 1);

        // grant then plain update
        sel_ready = 1'b1;
        step();
        chk("grant_pending", sel_valid, 0);
        upd_num = 2'd0;
        #1 chk("upd_mask_e0", upd_thread_mask, 32'hFFFF_FFFF);
        upd(2'd0, 32'h104, 1'b0, 1'b0, '0, '0);
        chk("upd_sel_valid", sel_valid, 1);
        chk("upd_sel_pc", sel_pc, 32'h104);
        chk("upd_sel_num", sel_num, 0);

        // divergence: entry 0 keeps high half, entry 1 takes low half
        step();
        upd(2'd0, 32'h108, 1'b0, 1'b1, 32'h0000_FFFF, 32'h200);
        chk("div_sel_num1", sel_num, 1);
        chk("div_sel_pc1", sel_pc, 32'h200);
        chk("div_sel_mask1", sel_mask, 32'h0000_FFFF);
        upd_num = 2'd0;
        #1 chk("div_e0_mask", upd_thread_mask, 32'hFFFF_0000);
        step();
        chk("alt_sel_num0", sel_num, 0);
        chk("alt_sel_pc0", sel_pc, 32'h108);
        step();
        chk("alt_none", sel_valid, 0);
        upd(2'd0, 32'hDEAD, 1'b1, 1'b0, '0, '0);
        chk("stall_sel_num", sel_num, 0);
        chk("stall_pc_kept", sel_pc, 32'h108);
        upd(2'd1, 32'hBEEF, 1'b1, 1'b0, '0, '0);
        chk("alt_sel_num1", sel_num, 1);
        chk("alt_sel_pc1", sel_pc, 32'h200);
        step();
        chk("both_pending", sel_valid, 0);
        sel_ready = 1'b0;

        // reconvergence at 0x300
        upd(2'd0, 32'h300, 1'b0, 1'b0, '0, '0);
        upd(2'd1, 32'h300, 1'b0, 1'b0, '0, '0);
        chk("pre_merge_num", sel_num, 0);
        chk("pre_merge_pc", sel_pc, 32'h300);
        step();
        chk("merge_mask", sel_mask, 32'hFFFF_FFFF);
        chk("merge_num", sel_num, 0);
        sel_ready = 1'b1;
        step();
        sel_ready = 1'b0;
        chk("merge_only_e0", sel_valid, 0);

        // fill all four entries
        upd(2'd0, 32'h304, 1'b0, 1'b1, 32'h0000_00FF, 32'h400);
        sel_ready = 1'b1;
        step(); step();
        sel_ready = 1'b0;
        chk("fill_all_pending", sel_valid, 0);
        upd(2'd0, 32'h308, 1'b0, 1'b1, 32'h0000_FF00, 32'h500);
        upd(2'd1, 32'h404, 1'b0, 1'b1, 32'h0000_000F, 32'h600);
        upd_num = 2'd2;
        #1 chk("fill_e2_mask", upd_thread_mask, 32'h0000_FF00);
        upd_num = 2'd3;
        #1 chk("fill_e3_mask", upd_thread_mask, 32'h0000_000F);
        chk("fill_sel_num", sel_num, 1);
        sel_ready = 1'b1;
        step();
        sel_ready = 1'b0;

        // table full: divergence on entry 1 is rejected
        upd(2'd1, 32'h408, 1'b0, 1'b1, 32'h0000_0030, 32'h700);
        chk("reject_pulse", div_reject, 1);
        upd_num = 2'd1;
        #1 chk("reject_mask_kept", upd_thread_mask, 32'h0000_00F0);
        wb(2'd2);
        chk("reject_one_cycle", div_reject, 0);
        wb(2'd3);
        wb(2'd0);
        chk("reject_sel_num", sel_num, 1);
        chk("reject_pc_kept", sel_pc, 32'h404);
        chk("reject_sel_mask", sel_mask, 32'h0000_00F0);
        chk("drain_busy", busy, 1);
        chk("drain_no_done", done, 0);

        // last writeback
        wb(2'd1);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_sel_valid", sel_valid, 0);
        step();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);

        // relaunch; init is ignored while running
        init_valid = 1'b1; init_pc = 32'h800; init_mask = 32'h0F0F_0F0F;
        step();
        init_pc = 32'h900;
        step();
        init_valid = 1'b0;
        chk("relaunch_busy", busy, 1);
        chk("relaunch_num", sel_num, 0);
        chk("relaunch_pc", sel_pc, 32'h800);
        chk("relaunch_mask", sel_mask, 32'h0F0F_0F0F);

        // three pending entries, then reset
        sel_ready = 1'b1;
        step();
        sel_ready = 1'b0;
        upd(2'd0, 32'h804, 1'b0, 1'b1, 32'h0000_000F, 32'hA00);
        sel_ready = 1'b1;
        step(); step();
        sel_ready = 1'b0;
        upd(2'd0, 32'h808, 1'b0, 1'b1, 32'h0000_0F00, 32'hB00);
        sel_ready = 1'b1;
        step(); step();
        sel_ready = 1'b0;
        chk("three_pending", sel_valid, 0);
        rst = 1'b1;
        step();
        chk("midrst_sel_valid", sel_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            upd_num = 2'(k);
            #1 chk($sformatf("midrst_mask%0d", k), upd_thread_mask, 0);
        end
        rst = 1'b0;
        step();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
